mem_stage: RTL and testbench

//  MEM pipeline stage downstream of the EXE/MEM register. Runs loads and stores against an

---
 rtl/mem_stage.sv | 109 ++++++++++
 tb/tb_mem_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a req/ack data memory for loads/stores, stalls the
// pipe for the access, and holds the MEM/WB register that feeds write-back.
module mem_stage #(
  parameter int unsigned AW      = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic          mem_wmem,
  input  logic [31:0]   mem_alu,
  input  logic [31:0]   mem_b,
  input  logic [4:0]    mem_rn,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic [31:0]   dmem_rdata,
  input  logic          dmem_ack,
  output logic          stall,
  output logic          dmem_err,
  output logic          wb_wreg,
  output logic          wb_m2reg,
  output logic [31:0]   wb_mo,
  output logic [31:0]   wb_alu,
  output logic [4:0]    wb_rn
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   data_q;
  logic          access_c;

  assign access_c = mem_m2reg | mem_wmem;

  // Hold upstream from the access cycle until the handshake has ended.
  assign stall = (state == S_REQ) || ((state == S_IDLE) && access_c);

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      cnt        <= '0;
      data_q     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_err   <= 1'b0;
      wb_wreg    <= 1'b0;
      wb_m2reg   <= 1'b0;
      wb_mo      <= '0;
      wb_alu     <= '0;
      wb_rn      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access_c) begin
            state      <= S_REQ;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_wmem;
            dmem_addr  <= mem_alu[AW+1:2];
            dmem_wdata <= mem_b;
            wb_wreg    <= 1'b0;
            wb_m2reg   <= 1'b0;
          end else begin
            wb_wreg  <= mem_wreg;
            wb_m2reg <= mem_m2reg;
            wb_alu   <= mem_alu;
            wb_rn    <= mem_rn;
            wb_mo    <= '0;
          end
        end
        S_REQ: begin
          wb_wreg  <= 1'b0;
          wb_m2reg <= 1'b0;
          if (dmem_ack) begin
            state    <= S_DONE;
            data_q   <= dmem_we ? 32'd0 : dmem_rdata;
            dmem_req <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // No ack in time: finish the instruction with zero data and flag it.
            state    <= S_DONE;
            data_q   <= '0;
            dmem_err <= 1'b1;
            dmem_req <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          wb_wreg  <= mem_wreg;
          wb_m2reg <= mem_m2reg;
          wb_alu   <= mem_alu;
          wb_rn    <= mem_rn;
          wb_mo    <= data_q;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instruction-level model of stall/handshake/write-back,
// checked every cycle at negedge, plus literal checks for the directed cases.
module tb_mem_stage;
  localparam int unsigned AW      = 10;
  localparam int unsigned TIMEOUT = 16;

  logic          clk;
  logic          clr;
  logic          mem_wreg, mem_m2reg, mem_wmem;
  logic [31:0]   mem_alu, mem_b;
  logic [4:0]    mem_rn;
  logic          dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic          dmem_ack;
  logic          stall, dmem_err;
  logic          wb_wreg, wb_m2reg;
  logic [31:0]   wb_mo, wb_alu;
  logic [4:0]    wb_rn;

  mem_stage #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem),
    .mem_alu(mem_alu), .mem_b(mem_b), .mem_rn(mem_rn),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .dmem_err(dmem_err),
    .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg), .wb_mo(wb_mo),
    .wb_alu(wb_alu), .wb_rn(wb_rn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Expected per-cycle outputs and the model's view of the MEM/WB register.
  logic          chk_on = 1'b0;
  logic          e_stall, e_req, e_we;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;
  logic          m_err, m_wreg, m_m2reg, m_full;
  logic [31:0]   m_alu, m_mo;
  logic [4:0]    m_rn;

  int            last_stalls;
  logic          last_we;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("stall", 32'(stall), 32'(e_stall));
      check("dmem_req", 32'(dmem_req), 32'(e_req));
      if (e_req) begin
        check("dmem_we", 32'(dmem_we), 32'(e_we));
        check("dmem_addr", 32'(dmem_addr), 32'(e_addr));
        check("dmem_wdata", dmem_wdata, e_wdata);
      end
      check("dmem_err", 32'(dmem_err), 32'(m_err));
      check("wb_wreg", 32'(wb_wreg), 32'(m_wreg));
      check("wb_m2reg", 32'(wb_m2reg), 32'(m_m2reg));
      if (m_full) begin
        check("wb_alu", wb_alu, m_alu);
        check("wb_rn", 32'(wb_rn), 32'(m_rn));
        check("wb_mo", wb_mo, m_mo);
      end
    end
  end

  // One clock: observe stall/request at negedge, then step past the edge.
  task automatic cycle();
    @(negedge clk);
    if (stall) last_stalls++;
    if (dmem_req) begin
      last_we    = dmem_we;
      last_addr  = dmem_addr;
      last_wdata = dmem_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb_bubble();
    m_wreg  = 1'b0;
    m_m2reg = 1'b0;
    m_full  = 1'b0;
  endtask

  task automatic wb_load(input logic wr, input logic ld, input logic [31:0] alu,
                         input logic [4:0] rn, input logic [31:0] mo);
    m_wreg  = wr;
    m_m2reg = ld;
    m_alu   = alu;
    m_rn    = rn;
    m_mo    = mo;
    m_full  = 1'b1;
  endtask

  task automatic drive(input logic wr, input logic ld, input logic st,
                       input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
    mem_wreg  = wr;
    mem_m2reg = ld;
    mem_wmem  = st;
    mem_alu   = alu;
    mem_b     = b;
    mem_rn    = rn;
  endtask

  // lat = REQ cycle (1-based) in which memory acks; 0 = never acks.
  task automatic issue(input logic wr, input logic ld, input logic st,
                       input logic [31:0] alu, input logic [31:0] b,
                       input logic [4:0] rn, input int lat);
    logic [31:0] data;
    int n;
    data        = 32'd0;
    last_stalls = 0;
    drive(wr, ld, st, alu, b, rn);
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    e_req      = 1'b0;
    if (!(ld | st)) begin
      e_stall = 1'b0;
      cycle();
      wb_load(wr, ld, alu, rn, 32'd0);
      return;
    end
    e_stall = 1'b1;
    cycle();
    wb_bubble();
    n = (lat == 0) ? int'(TIMEOUT) : lat;
    for (int k = 1; k <= n; k++) begin
      e_req      = 1'b1;
      e_we       = st;
      e_addr     = alu[AW+1:2];
      e_wdata    = b;
      dmem_ack   = (k == lat);
      dmem_rdata = $urandom;
      if (k == lat) data = st ? 32'd0 : dmem_rdata;
      cycle();
      wb_bubble();
    end
    if (lat == 0) m_err = 1'b1;
    e_req    = 1'b0;
    e_stall  = 1'b0;
    dmem_ack = 1'($urandom_range(0, 1));
    cycle();
    wb_load(wr, ld, alu, rn, data);
  endtask

  task automatic model_reset();
    m_err = 1'b0;
    wb_load(1'b0, 1'b0, 32'd0, 5'd0, 32'd0);
    e_req   = 1'b0;
    e_stall = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
    chk_on = 1'b1;
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_wb_alu", wb_alu, 32'd0);

    // ALU op passes straight through
    issue(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd5, 1);
    check("t1_wb_alu", wb_alu, 32'h0000_1234);
    check("t1_wb_rn", 32'(wb_rn), 32'd5);
    check("t1_wb_wreg", 32'(wb_wreg), 32'd1);
    check("t1_stalls", 32'(last_stalls), 32'd0);

    // Fastest load
    issue(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 5'd7, 1);
    check("t2_addr", 32'(last_addr), 32'h10);
    check("t2_stalls", 32'(last_stalls), 32'd2);
    check("t2_wb_m2reg", 32'(wb_m2reg), 32'd1);
    check("t2_wb_mo_nonzero_rd", 32'(wb_mo == m_mo), 32'd1);
    // Same load again with a fixed read value to pin the data path.
    last_stalls = 0;
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 5'd7);
    dmem_ack = 1'b0; e_stall = 1'b1; e_req = 1'b0;
    cycle(); wb_bubble();
    e_req = 1'b1; e_we = 1'b0; e_addr = 10'h10; e_wdata = 32'd0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    cycle(); wb_bubble();
    e_req = 1'b0; e_stall = 1'b0; dmem_ack = 1'b0;
    cycle();
    wb_load(1'b1, 1'b1, 32'h40, 5'd7, 32'hCAFE_F00D);
    check("t2_wb_mo", wb_mo, 32'hCAFE_F00D);

    // Store with ack in third REQ cycle
    issue(1'b0, 1'b0, 1'b1, 32'h8, 32'hA5A5_A5A5, 5'd3, 3);
    check("t3_we", 32'(last_we), 32'd1);
    check("t3_addr", 32'(last_addr), 32'd2);
    check("t3_wdata", last_wdata, 32'hA5A5_A5A5);
    check("t3_stalls", 32'(last_stalls), 32'd4);
    check("t3_wb_wreg", 32'(wb_wreg), 32'd0);

    // Load that never gets an ack
    issue(1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 5'd9, 0);
    check("t4_req", 32'(dmem_req), 32'd0);
    check("t4_err", 32'(dmem_err), 32'd1);
    check("t4_wb_mo", wb_mo, 32'd0);
    check("t4_stalls", 32'(last_stalls), 32'(TIMEOUT + 1));
    issue(1'b1, 1'b1, 1'b0, 32'h104, 32'd0, 5'd10, 2);
    check("t4_err_sticky", 32'(dmem_err), 32'd1);

    // Back-to-back load then store
    issue(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 5'd11, 1);
    check("t6_ld_stalls", 32'(last_stalls), 32'd2);
    check("t6_ld_rn", 32'(wb_rn), 32'd11);
    issue(1'b0, 1'b0, 1'b1, 32'h24, 32'h1357_9BDF, 5'd12, 1);
    check("t6_st_stalls", 32'(last_stalls), 32'd2);
    check("t6_st_rn", 32'(wb_rn), 32'd12);

    // Reset in the middle of a request; a late ack must be ignored
    drive(1'b1, 1'b1, 1'b0, 32'h80, 32'd0, 5'd13);
    dmem_ack = 1'b0; e_stall = 1'b1; e_req = 1'b0;
    cycle(); wb_bubble();
    e_req = 1'b1; e_we = 1'b0; e_addr = 10'h20; e_wdata = 32'd0;
    repeat (3) begin cycle(); wb_bubble(); end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 5'd0);
    dmem_ack = 1'b1;
    @(negedge clk);
    check("t5_stall", 32'(stall), 32'd0);
    check("t5_req", 32'(dmem_req), 32'd0);
    check("t5_err", 32'(dmem_err), 32'd0);
    check("t5_wb_wreg", 32'(wb_wreg), 32'd0);
    @(posedge clk); #1;
    check("t5_late_ack_req", 32'(dmem_req), 32'd0);

    // Random instruction stream
    for (int i = 0; i < 80; i++) begin
      int r, lat;
      r   = int'($urandom_range(0, 9));
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      if (r < 4)
        issue(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), lat);
      else if (r < 7)
        issue(1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'($urandom), lat);
      else
        issue(1'($urandom_range(0, 1)), 1'b0, 1'b1, $urandom, $urandom, 5'($urandom), lat);
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
